johnson_ring_counter: RTL
=========================

JOHNSON_RING_COUNTER -- requirements
Module: johnson_ring_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter register width; legal range 2..32.
REQ-002 Derived constant: PW = clog2(2*WIDTH), phase output width.
REQ-003 Port: clk  in  1  single clock; all state changes on the falling edge.
REQ-004 Port: sync_reset  in  1  reset, synchronous and active-high, sampled on the falling edge of clk.
REQ-005 Port: en  in  1  advance enable; the counter holds when low.
REQ-006 Port: mode  in  1  0 = Johnson (twisted ring, period 2*WIDTH); 1 = ring (one-hot, period WIDTH).
REQ-007 Port: dir  in  1  0 = shift toward MSB; 1 = shift toward LSB.
REQ-008 Port: load  in  1  synchronous parallel load strobe.
REQ-009 Port: load_value  in  WIDTH  value written on load.
REQ-010 Port: out  out  WIDTH  registered counter state.
REQ-011 Port: phase  out  PW  combinational sequence index of out.
REQ-012 Port: tc  out  1  combinational terminal-count flag.
REQ-013 Port: illegal  out  1  combinational flag; high when out is not a legal state for the current mode.

Function
REQ-014 The start pattern SHALL be all-zeros in Johnson mode and 0...01 in ring mode.
REQ-015 Priority on each falling edge SHALL be: sync_reset > load > en; with none of them active, out holds.
REQ-016 A load SHALL write load_value unmodified, even when that value is illegal.
REQ-017 With en=1 and a legal state, Johnson dir=0 SHALL produce {out[W-2:0], ~out[W-1]}, and Johnson dir=1 SHALL produce {~out[0], out[W-1:1]}.
REQ-018 With en=1 and a legal state, ring dir=0 SHALL produce {out[W-2:0], out[W-1]}, and ring dir=1 SHALL produce {out[0], out[W-1:1]}.
REQ-019 Legal Johnson states are the 2*WIDTH patterns reachable from all-zeros; legal ring states are the WIDTH one-hot patterns.
REQ-020 With en=1 and illegal=1, the next edge SHALL load the start pattern of the current mode (self-correction, one cycle).
REQ-021 A mode change SHALL take effect immediately in illegal, phase and tc; the state is corrected by REQ-020 on the next enabled edge.
REQ-022 In Johnson mode, phase SHALL be popcount(out) when out[W-1]=0, otherwise 2*WIDTH - popcount(out).
REQ-023 In ring mode, phase SHALL be the index of the set bit.
REQ-024 Phase SHALL be 0 while illegal=1.
REQ-025 The tc flag SHALL be high only when all of the following hold: en=1, load=0, sync_reset=0, illegal=0, and the next advance yields the start pattern.
REQ-026 The tc flag SHALL therefore pulse once every 2*WIDTH enabled cycles in Johnson mode and once every WIDTH in ring mode, in either direction.
REQ-027 Direction reversal mid-sequence SHALL step back to the previous legal state, with no skipped or repeated state.

Reset
REQ-028 On sync_reset, out SHALL become the start pattern of the mode sampled at that edge: Johnson 0, ring 1.
REQ-029 After reset, phase=0, illegal=0, and tc follows REQ-025.
REQ-030 Reset mid-sequence or coincident with load or en SHALL override both within the same edge.
REQ-031 No asynchronous reset path SHALL exist.

Structure
REQ-032 The mode and direction encodings and the start-pattern function SHALL reside in shared package counter_pkg.
REQ-033 Each state bit SHALL be one instance of sub-module falling_edge_dff_sync_reset_high (ports: d, clk, sync_reset, en, rst_val, q).
REQ-034 Next-state, legality, phase and tc logic SHALL be combinational in the top level.

Verification (WIDTH=4)
REQ-035 Reset with mode=0, then 8 cycles of en=1, dir=0 -> out 0000,0001,0011,0111,1111,1110,1100,1000,0000; tc high only in the cycle holding 1000.
REQ-036 Reset with mode=1, dir=1, en=1 -> out 0001,1000,0100,0010,0001; phase 0,3,2,1,0; tc high at 0010.
REQ-037 Load 0101 in mode 0 -> illegal=1 and phase=0; the next enabled edge gives out=0000 and illegal=0.
REQ-038 In mode 0 at out=0111 (phase 3), set dir=1 for one edge -> out=0011 (phase 2).
REQ-039 At out=1110 assert sync_reset and load together, with load_value=1111 -> out=0000.
REQ-040 At out=0011 switch mode to 1 -> illegal=1 at once; the next enabled edge gives out=0001.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction encodings and start-pattern function
package counter_pkg;
  typedef enum logic {MODE_JOHNSON = 1'b0, MODE_RING = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  // Johnson sequences begin at all-zeros, ring sequences at a single LSB one
  function automatic logic [31:0] start_pattern(input logic mode);
    return (mode == MODE_RING) ? 32'd1 : 32'd0;
  endfunction
endpackage

// File: rtl/falling_edge_dff_sync_reset_high.sv
// falling_edge_dff_sync_reset_high: one state bit, negedge clocked, sync active-high reset to rst_val
module falling_edge_dff_sync_reset_high (
  input  logic d,
  input  logic clk,
  input  logic sync_reset,
  input  logic en,
  input  logic rst_val,
  output logic q
);
  // reset wins over enable; otherwise capture d when enabled
  always_ff @(negedge clk)
    if (sync_reset) q <= rst_val;
    else if (en) q <= d;
endmodule

// File: rtl/johnson_ring_counter.sv
// johnson_ring_counter: Johnson/ring counter with load, direction, self-correction, phase and terminal count
module johnson_ring_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             tc,
  output logic             illegal
);
  logic [WIDTH-1:0] out_d, out_q, start, adv;
  logic [PW-1:0] pc, tr, idx;
  logic ring, down, flop_en;
  // Legality from popcount (ring) or count of adjacent-bit transitions (Johnson: at most one),
  // then next state, phase and terminal count
  always_comb begin
    pc = '0;
    tr = '0;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PW'(out_q[i]);
      idx = out_q[i] ? PW'(i) : idx;
    end
    for (int i = 0; i < WIDTH - 1; i++) tr = tr + PW'(out_q[i] ^ out_q[i + 1]);
    ring = mode == MODE_RING;
    down = dir == DIR_DOWN;
    start = WIDTH'(start_pattern(mode));
    illegal = ring ? (pc != PW'(1)) : (tr > PW'(1));
    adv = down ? {out_q[0] ^ ~ring, out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], out_q[WIDTH-1] ^ ~ring};
    out_d = load ? load_value : illegal ? start : adv;
    flop_en = load | en;
    phase = illegal ? '0 : ring ? idx : out_q[WIDTH-1] ? PW'(2 * WIDTH) - pc : pc;
    tc = en & ~load & ~sync_reset & ~illegal & (adv == start);
  end
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    falling_edge_dff_sync_reset_high u_dff (
      .d(out_d[b]),
      .clk(clk),
      .sync_reset(sync_reset),
      .en(flop_en),
      .rst_val(start[b]),
      .q(out_q[b])
    );
  end
  assign out = out_q;
endmodule
